rv_mtimer: RTL and testbench

- Parametrised machine-timer peripheral for the rv32 core family.
- Generalises the single mtime/mtimecmp pair: 1..8 compare channels, a programmable prescaler, a run/stop control, and per-channel interrupt enables.
- Adds a coherent 64-bit mtime read through a high-word snapshot.
- Sits on the core data bus beside RAM; its registered read data is OR-ed with memory read data. Its interrupt output drives the core timer-interrupt request.

---
 rtl/rv_mtimer_if.sv | 24 ++
 rtl/rv_mtimer.sv | 146 ++++++++++++++
 tb/tb_rv_mtimer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mtimer_if.sv
// Data-bus bundle between the rv32 core and the machine-timer peripheral.
// Signals are sampled on clk edges where d_rdy=1; d_dr is registered read data, zero unless a read hit.
interface rv_mtimer_if #(
  parameter int NCH = 2
);
  logic [31:0]    d_adr;
  logic [31:0]    d_dw;
  logic [3:0]     d_we;
  logic           d_re;
  logic           d_rdy;
  logic [31:0]    d_dr;
  logic [NCH-1:0] mtirq;
  logic           irq;

  modport master (
    output d_adr, d_dw, d_we, d_re, d_rdy,
    input  d_dr, mtirq, irq
  );

  modport slave (
    input  d_adr, d_dw, d_we, d_re, d_rdy,
    output d_dr, mtirq, irq
  );
endinterface

// File: rtl/rv_mtimer.sv
// Machine timer: 64-bit mtime with prescaler and run control, NCH compare channels,
// per-channel interrupt enables, and a high-word snapshot for coherent 64-bit reads.
module rv_mtimer #(
  parameter int          NCH  = 2,
  parameter logic [31:0] BASE = 32'hffff8000,
  parameter int          PW   = 8
) (
  input logic         clk,
  input logic         xreset,
  rv_mtimer_if.slave  bus
);

  localparam logic [4:0] OFF_LO   = 5'd0;
  localparam logic [4:0] OFF_HI   = 5'd1;
  localparam logic [4:0] OFF_CTRL = 5'd2;
  localparam int         OFF_CMP  = 4;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] dw,
                                          input logic [3:0]  we);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = dw[8*i +: 8];
    end
    return res;
  endfunction

  logic [63:0]    r_mtime;
  logic [31:0]    r_snap;
  logic [PW-1:0]  r_pcnt;
  logic           r_run;
  logic [PW-1:0]  r_presc;
  logic [NCH-1:0] r_ien;
  logic [63:0]    r_cmp [NCH];
  logic [NCH-1:0] r_mtirq;
  logic           r_irq;
  logic [31:0]    r_dr;

  logic        w_sel, w_wr, w_rd;
  logic [4:0]  w_off;
  logic        w_wr_lo, w_wr_hi, w_wr_ctrl, w_rd_lo;
  logic        w_tick;
  logic [31:0] w_ctrl, w_stat, w_ctrl_wr, w_lo_wr, w_hi_wr, w_rdata;
  logic [63:0] w_mtime_inc;
  logic        w_unused_bits;

  assign w_sel     = (bus.d_adr[31:7] == BASE[31:7]);
  assign w_off     = bus.d_adr[6:2];
  assign w_wr      = bus.d_rdy & w_sel & (|bus.d_we);
  assign w_rd      = bus.d_rdy & w_sel & bus.d_re;
  assign w_wr_lo   = w_wr && (w_off == OFF_LO);
  assign w_wr_hi   = w_wr && (w_off == OFF_HI);
  assign w_wr_ctrl = w_wr && (w_off == OFF_CTRL);
  assign w_rd_lo   = w_rd && (w_off == OFF_LO);

  assign w_tick      = r_run && (r_pcnt == r_presc);
  assign w_mtime_inc = r_mtime + 64'd1;
  assign w_ctrl_wr   = f_merge(w_ctrl, bus.d_dw, bus.d_we);
  assign w_lo_wr     = f_merge(r_mtime[31:0], bus.d_dw, bus.d_we);
  assign w_hi_wr     = f_merge(r_mtime[63:32], bus.d_dw, bus.d_we);
  assign w_unused_bits = ^{bus.d_adr[1:0], w_ctrl_wr};

  always_comb begin
    w_ctrl = '0;
    w_ctrl[0] = r_run;
    w_ctrl[8 +: PW] = r_presc;
    w_ctrl[16 +: NCH] = r_ien;
    w_stat = '0;
    w_stat[NCH-1:0] = r_mtirq;
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_LO:   w_rdata = r_mtime[31:0];
      OFF_HI:   w_rdata = r_snap;
      OFF_CTRL: w_rdata = w_ctrl;
      5'd3:     w_rdata = w_stat;
      default: begin
        for (int k = 0; k < NCH; k++) begin
          if (w_off == 5'(OFF_CMP + 2*k))     w_rdata = r_cmp[k][31:0];
          if (w_off == 5'(OFF_CMP + 2*k + 1)) w_rdata = r_cmp[k][63:32];
        end
      end
    endcase
  end

  // A bus write to either mtime word overrides the tick: no increment, no carry.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_mtime <= '0;
      r_snap  <= '0;
      r_pcnt  <= '0;
      r_run   <= 1'b1;
      r_presc <= '0;
      r_ien   <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_run   <= w_ctrl_wr[0];
        r_presc <= w_ctrl_wr[8 +: PW];
        r_ien   <= w_ctrl_wr[16 +: NCH];
        r_pcnt  <= '0;
      end else if (r_run) begin
        r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
      end

      if (w_wr_lo)      r_mtime[31:0]  <= w_lo_wr;
      else if (w_wr_hi) r_mtime[63:32] <= w_hi_wr;
      else if (w_tick)  r_mtime        <= w_mtime_inc;

      if (w_wr_hi)      r_snap <= w_hi_wr;
      else if (w_rd_lo) r_snap <= r_mtime[63:32];
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      for (int k = 0; k < NCH; k++) r_cmp[k] <= '1;
      r_mtirq <= '0;
      r_irq   <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_wr && (w_off == 5'(OFF_CMP + 2*k)))
          r_cmp[k][31:0] <= f_merge(r_cmp[k][31:0], bus.d_dw, bus.d_we);
        if (w_wr && (w_off == 5'(OFF_CMP + 2*k + 1)))
          r_cmp[k][63:32] <= f_merge(r_cmp[k][63:32], bus.d_dw, bus.d_we);
        r_mtirq[k] <= (r_mtime >= r_cmp[k]);
      end
      r_irq <= |(r_mtirq & r_ien);
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_dr <= '0;
    end else if (bus.d_rdy) begin
      r_dr <= w_rd ? w_rdata : '0;
    end
  end

  assign bus.d_dr  = r_dr;
  assign bus.mtirq = r_mtirq;
  assign bus.irq   = r_irq;

endmodule

// File: tb/tb_rv_mtimer.sv
// Directed bench for rv_mtimer: a register-access vector table plus timed sequences
// for prescaled compare, carry coherence, write-vs-tick priority and mid-run reset.
module tb_rv_mtimer;

  localparam logic [31:0] A_LO    = 32'hffff8000;
  localparam logic [31:0] A_HI    = 32'hffff8004;
  localparam logic [31:0] A_CTRL  = 32'hffff8008;
  localparam logic [31:0] A_STAT  = 32'hffff800c;
  localparam logic [31:0] A_C0LO  = 32'hffff8010;
  localparam logic [31:0] A_C0HI  = 32'hffff8014;
  localparam logic [31:0] A_C1LO  = 32'hffff8018;
  localparam logic [31:0] A_C1HI  = 32'hffff801c;
  localparam logic [31:0] A_7C    = 32'hffff807c;
  localparam logic [31:0] A_OUT   = 32'hffff0008;

  localparam int OP_W = 0;
  localparam int OP_R = 1;
  localparam int OP_I = 2;

  typedef struct {
    int          op;
    logic [31:0] adr;
    logic [31:0] dw;
    logic [3:0]  we;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk;
  logic xreset;
  int   n_chk;
  int   n_err;
  vec_t tbl[$];

  rv_mtimer_if #(.NCH(2)) mif ();

  rv_mtimer #(.NCH(2), .BASE(32'hffff8000), .PW(8)) dut (
    .clk    (clk),
    .xreset (xreset),
    .bus    (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All drivers are entered at a negedge and return at the following negedge.
  task automatic bus_write(input logic [31:0] adr, input logic [31:0] dw, input logic [3:0] we);
    mif.d_adr = adr; mif.d_dw = dw; mif.d_we = we; mif.d_re = 1'b0;
    @(negedge clk);
    mif.d_we = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] adr, output logic [31:0] data);
    mif.d_adr = adr; mif.d_we = 4'b0000; mif.d_re = 1'b1;
    @(negedge clk);
    mif.d_re = 1'b0;
    data = mif.d_dr;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input int op, input logic [31:0] adr, input logic [31:0] dw,
                     input logic [3:0] we, input logic [31:0] exp, input string name);
    vec_t v;
    v.op = op; v.adr = adr; v.dw = dw; v.we = we; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, lo, hi;
    int first_m, first_i;
    n_chk = 0; n_err = 0;
    xreset = 1'b0;
    mif.d_adr = '0; mif.d_dw = '0; mif.d_we = '0; mif.d_re = 1'b0; mif.d_rdy = 1'b1;

    add(OP_W, A_CTRL, 32'h0, 4'hf, 32'h0, "ctrl_stop");
    add(OP_W, A_LO,   32'h12345678, 4'hf, 32'h0, "w_lo");
    add(OP_W, A_HI,   32'h9abcdef0, 4'hf, 32'h0, "w_hi");
    add(OP_R, A_CTRL, 32'h0, 4'h0, 32'h00000000, "ctrl_stopped");
    add(OP_R, A_LO,   32'h0, 4'h0, 32'h12345678, "mtime_lo");
    add(OP_R, A_HI,   32'h0, 4'h0, 32'h9abcdef0, "mtime_hi_snap");
    add(OP_W, A_HI,   32'h11111111, 4'hf, 32'h0, "w_hi2");
    add(OP_R, A_HI,   32'h0, 4'h0, 32'h11111111, "snap_from_hi_write");
    add(OP_R, A_LO,   32'h0, 4'h0, 32'h12345678, "mtime_lo2");
    add(OP_W, A_C1LO, 32'h0000ab00, 4'b0010, 32'h0, "w_cmp1_byte");
    add(OP_R, A_C1LO, 32'h0, 4'h0, 32'hffffabff, "cmp1_lo_byte");
    add(OP_R, A_C1HI, 32'h0, 4'h0, 32'hffffffff, "cmp1_hi");
    add(OP_W, A_STAT, 32'hffffffff, 4'hf, 32'h0, "w_status");
    add(OP_R, A_STAT, 32'h0, 4'h0, 32'h00000000, "status_ro");
    add(OP_W, A_7C,   32'hffffffff, 4'hf, 32'h0, "w_7c");
    add(OP_R, A_7C,   32'h0, 4'h0, 32'h00000000, "unmapped_7c");
    add(OP_W, A_OUT,  32'h00000001, 4'hf, 32'h0, "w_outside");
    add(OP_R, A_CTRL, 32'h0, 4'h0, 32'h00000000, "ctrl_outside_ignored");
    add(OP_R, A_OUT,  32'h0, 4'h0, 32'h00000000, "outside_read");
    add(OP_W, A_CTRL, 32'h00ffff00, 4'hf, 32'h0, "w_ctrl_mask");
    add(OP_R, A_CTRL, 32'h0, 4'h0, 32'h0003ff00, "ctrl_mask");
    add(OP_W, A_CTRL, 32'h0, 4'hf, 32'h0, "ctrl_stop2");
    add(OP_W, A_C0LO, 32'h5, 4'hf, 32'h0, "w_cmp0_lo");
    add(OP_W, A_C0HI, 32'h0, 4'hf, 32'h0, "w_cmp0_hi");
    add(OP_I, 32'h0,  32'h0, 4'h0, 32'h0, "idle");
    add(OP_R, A_STAT, 32'h0, 4'h0, 32'h00000001, "status_pending");
    add(OP_R, A_C0LO, 32'h0, 4'h0, 32'h00000005, "cmp0_lo");
    add(OP_W, A_LO,   32'haaaaaaaa, 4'b1001, 32'h0, "w_lo_bytes");
    add(OP_R, A_LO,   32'h0, 4'h0, 32'haa3456aa, "lo_bytes");

    // Reset state and free-running count from reset.
    repeat (3) @(negedge clk);
    check("rst_d_dr", mif.d_dr, 32'h0);
    check("rst_mtirq", 32'(mif.mtirq), 32'h0);
    check("rst_irq", 32'(mif.irq), 32'h0);
    xreset = 1'b1;
    idle(10);
    check("idle_d_dr", mif.d_dr, 32'h0);
    check("idle_mtirq", 32'(mif.mtirq), 32'h0);
    bus_read(A_LO, rd);
    check("count_after_10", rd, 32'd10);

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_W: bus_write(tbl[i].adr, tbl[i].dw, tbl[i].we);
        OP_R: begin
          bus_read(tbl[i].adr, rd);
          check(tbl[i].name, rd, tbl[i].exp);
        end
        default: idle(1);
      endcase
    end

    // Prescale 3: mtime steps every 4 clk; mtirq[0] after mtime hits 20, irq one later.
    bus_write(A_C0LO, 32'd20, 4'hf);
    bus_write(A_LO, 32'h0, 4'hf);
    bus_write(A_HI, 32'h0, 4'hf);
    bus_write(A_CTRL, 32'h00010301, 4'hf);
    first_m = -1; first_i = -1;
    for (int c = 1; c <= 200 && first_i < 0; c++) begin
      @(negedge clk);
      if (first_m < 0 && mif.mtirq[0]) first_m = c;
      if (first_i < 0 && mif.irq) first_i = c;
    end
    check("mtirq0_rise_cycle", 32'(first_m), 32'd81);
    check("irq_rise_cycle", 32'(first_i), 32'd82);
    check("mtirq1_quiet", 32'(mif.mtirq[1]), 32'h0);
    bus_write(A_C0LO, 32'hfffffff0, 4'hf);
    idle(2);
    check("mtirq0_cleared", 32'(mif.mtirq), 32'h0);
    check("irq_cleared", 32'(mif.irq), 32'h0);

    // Write to MTIME_LO on a tick cycle beats the increment and carry.
    bus_write(A_CTRL, 32'h0, 4'hf);
    bus_write(A_HI, 32'h1, 4'hf);
    bus_write(A_LO, 32'hffffffff, 4'hf);
    bus_write(A_CTRL, 32'h1, 4'hf);
    bus_write(A_LO, 32'h00000055, 4'hf);
    bus_read(A_LO, lo);
    bus_read(A_HI, hi);
    check("tick_write_lo", lo, 32'h00000055);
    check("tick_write_hi", hi, 32'h00000001);

    // Coherent 64-bit read across a low-word carry.
    bus_write(A_CTRL, 32'h0, 4'hf);
    bus_write(A_LO, 32'hfffffffe, 4'hf);
    bus_write(A_HI, 32'h0, 4'hf);
    bus_write(A_CTRL, 32'h1, 4'hf);
    bus_read(A_LO, lo);
    bus_read(A_HI, hi);
    check("carry_pre_lo", lo, 32'hfffffffe);
    check("carry_pre_hi", hi, 32'h0);
    bus_read(A_LO, lo);
    bus_read(A_HI, hi);
    check("carry_post_lo", lo, 32'h00000000);
    check("carry_post_hi", hi, 32'h00000001);
    check("carry_coherent", 32'((hi == 32'h1) && (lo < 32'h10)), 32'h1);

    // Mid-run reset with pending interrupt and d_dr held by d_rdy=0.
    bus_write(A_CTRL, 32'h00010000, 4'hf);
    bus_write(A_LO, 32'h00c0ffee, 4'hf);
    bus_write(A_HI, 32'h0, 4'hf);
    bus_write(A_C0LO, 32'h0, 4'hf);
    bus_write(A_C0HI, 32'h0, 4'hf);
    idle(2);
    check("pre_rst_mtirq", 32'(mif.mtirq), 32'h1);
    check("pre_rst_irq", 32'(mif.irq), 32'h1);
    bus_read(A_LO, rd);
    check("pre_rst_read", rd, 32'h00c0ffee);
    mif.d_rdy = 1'b0;
    mif.d_adr = A_CTRL; mif.d_re = 1'b1;
    idle(2);
    check("d_dr_hold", mif.d_dr, 32'h00c0ffee);
    #3 xreset = 1'b0;
    #1;
    check("rst_now_d_dr", mif.d_dr, 32'h0);
    check("rst_now_mtirq", 32'(mif.mtirq), 32'h0);
    check("rst_now_irq", 32'(mif.irq), 32'h0);
    @(negedge clk);
    mif.d_re = 1'b0;
    mif.d_rdy = 1'b1;
    xreset = 1'b1;
    bus_read(A_CTRL, rd);
    check("rst_ctrl", rd, 32'h00000001);
    bus_read(A_C0LO, rd);
    check("rst_cmp0_lo", rd, 32'hffffffff);
    bus_read(A_C0HI, rd);
    check("rst_cmp0_hi", rd, 32'hffffffff);
    bus_read(A_C1LO, rd);
    check("rst_cmp1_lo", rd, 32'hffffffff);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
